// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer SRAM arbiter.
package vga_pkg;

  typedef enum logic [1:0] {IDLE, PRE, WR0, WR1} arb_state_e;

  // Active-low {ub_n, lb_n} for a single-pixel write; odd pixels live in the high byte.
  function automatic logic [1:0] byte_en_n(input logic hi);
    return hi ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/vram_wr_buffer.sv
// Single-entry holding register for core pixel writes (valid/ready).
module vram_wr_buffer #(
  parameter int AWIDTH = 19,
  parameter int PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [PWIDTH-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr,
  output logic              buf_vld,
  output logic [AWIDTH-1:0] buf_addr,
  output logic [PWIDTH-1:0] buf_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (clr) begin
      buf_vld <= 1'b0;
    end else if (wr_req && !buf_vld) begin
      buf_vld  <= 1'b1;
      buf_addr <= wr_addr;
      buf_data <= wr_data;
    end
  end

  assign wr_ready = !buf_vld;

endmodule

// File: rtl/vga_vram_sram_arbiter.sv
// Frame-buffer SRAM arbiter: pipelined VGA pixel reads with priority,
// core pixel writes slotted into read gaps or forced after starvation.
module vga_vram_sram_arbiter
  import vga_pkg::*;
#(
  parameter int AWIDTH     = 19,
  parameter int PWIDTH     = 8,
  parameter int SAWIDTH    = 18,
  parameter int SDWIDTH    = 16,
  parameter int STARVE_MAX = 16
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic [AWIDTH-1:0]  vram_addr,
  input  logic               vram_rd,
  output logic [PWIDTH-1:0]  vram_data,
  output logic               vram_vld,
  output logic               vram_busy,
  output logic               rd_drop_err,
  input  logic               wr_req,
  input  logic [AWIDTH-1:0]  wr_addr,
  input  logic [PWIDTH-1:0]  wr_data,
  output logic               wr_ready,
  output logic [SAWIDTH-1:0] sram_addr,
  inout  wire  [SDWIDTH-1:0] sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  arb_state_e        state;
  logic [7:0]        starve_cnt;
  logic              buf_vld;
  logic [AWIDTH-1:0] buf_addr;
  logic [PWIDTH-1:0] buf_data;
  logic              dq_oe;
  logic              rd_acc, go;
  logic [2:1]        vld_pipe;
  logic              rd_hi;

  vram_wr_buffer #(.AWIDTH(AWIDTH), .PWIDTH(PWIDTH)) u_wbuf (
    .clk      (clk_core),
    .rst_n    (rst_core_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clr      (state == WR1),
    .buf_vld  (buf_vld),
    .buf_addr (buf_addr),
    .buf_data (buf_data)
  );

  assign rd_acc = vram_rd && !vram_busy;
  assign go     = (state == IDLE) && buf_vld && (!vram_rd || starve_cnt == STARVE_LIM);

  // Busy is registered next_state != IDLE, so reads are only ever accepted in IDLE.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state      <= IDLE;
      vram_busy  <= 1'b0;
      starve_cnt <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      dq_oe      <= 1'b0;
    end else begin
      sram_we_n <= 1'b1;
      case (state)
        IDLE: begin
          if (rd_acc) begin
            sram_addr <= vram_addr[AWIDTH-1:1];
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            {sram_ub_n, sram_lb_n} <= 2'b00;
          end else begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            {sram_ub_n, sram_lb_n} <= 2'b11;
          end
          if (go) begin
            state      <= PRE;
            vram_busy  <= 1'b1;
            starve_cnt <= '0;
          end else if (buf_vld && vram_rd && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        // The read accepted on the way in occupies the SRAM during PRE.
        PRE: begin
          state     <= WR0;
          sram_addr <= buf_addr[AWIDTH-1:1];
          sram_ce_n <= 1'b0;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b0;
          {sram_ub_n, sram_lb_n} <= byte_en_n(buf_addr[0]);
          dq_oe     <= 1'b1;
        end
        WR0: state <= WR1;
        WR1: begin
          state     <= IDLE;
          vram_busy <= 1'b0;
          dq_oe     <= 1'b0;
          sram_ce_n <= 1'b1;
          {sram_ub_n, sram_lb_n} <= 2'b11;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sram_dq = dq_oe ? {2{buf_data}} : {SDWIDTH{1'bz}};

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      vld_pipe    <= '0;
      rd_hi       <= 1'b0;
      vram_data   <= '0;
      rd_drop_err <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[1], rd_acc};
      rd_drop_err <= vram_rd && vram_busy;
      if (rd_acc) rd_hi <= vram_addr[0];
      if (vld_pipe[1])
        vram_data <= rd_hi ? sram_dq[SDWIDTH-1:PWIDTH] : sram_dq[PWIDTH-1:0];
    end
  end

  assign vram_vld = vld_pipe[2];

endmodule

// File: doc/vga_vram_sram_arbiter.md
Name: vga_vram_sram_arbiter

Overview:
- Upstream neighbour of vga_controller. Owns the external 16-bit asynchronous SRAM that holds the frame buffer.
- Serves the controller's pixel-read port (vram_addr/vram_rd -> vram_data/vram_vld, vram_busy) and a single-entry core pixel-write port.
- VGA reads have priority. Core writes are slotted in when reads pause, or forced by a starvation counter.
- Two 8-bit pixels are packed per SRAM word.

Parameters:
- AWIDTH, 19, pixel address width (matches vga_controller)
- PWIDTH, 8, pixel width; must equal SDWIDTH/2
- SAWIDTH, 18, SRAM word address width; must equal AWIDTH-1
- SDWIDTH, 16, SRAM data width
- STARVE_MAX, 16, read cycles a pending write may wait before a write slot is forced; range 1..255

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- vram_addr  in  AWIDTH  pixel read address
- vram_rd  in  1  read request; accepted whenever vram_busy=0
- vram_data  out  PWIDTH  read pixel
- vram_vld  out  1  one-cycle pulse qualifying vram_data
- vram_busy  out  1  registered; reads not accepted while high
- rd_drop_err  out  1  one-cycle pulse: vram_rd seen while vram_busy=1
- wr_req  in  1  core write request
- wr_addr  in  AWIDTH  write pixel address
- wr_data  in  PWIDTH  write pixel
- wr_ready  out  1  write buffer empty; handshake completes on wr_req & wr_ready
- sram_addr  out  SAWIDTH  word address
- sram_dq  inout  SDWIDTH  data bus; tri-stated except during WR0/WR1
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Clock/reset: single clock clk_core; reset rst_core_n is asynchronous, active-low. All flops clear immediately on assertion.
- Reset values:
  - state=IDLE, vram_busy=0, vram_vld=0, vram_data=0, rd_drop_err=0, wr_ready=1
  - sram_we_n=1, sram_oe_n=1, sram_ce_n=1, sram_ub_n=1, sram_lb_n=1, sram_addr=0, sram_dq=Z
  - starve counter=0, write buffer empty
- Reset mid-write: we_n returns high and dq releases asynchronously; the buffered write is discarded and not retried.
- Address mapping: sram_addr = addr[AWIDTH-1:1]. addr[0]=0 selects dq[7:0]/lb_n; addr[0]=1 selects dq[15:8]/ub_n.
- Read pipeline, fully pipelined at one read per cycle:
  - Cycle T: vram_rd=1 with busy=0 -> accepted.
  - T+1: sram_addr registered, ce_n=0, oe_n=0, ub_n=lb_n=0; SRAM data sampled at the end of the cycle.
  - T+2: vram_vld=1, vram_data = selected byte (selection uses the registered addr[0]).
  - Latency is fixed at 2 cycles with no bubbles.
  - When no read is at T+1, oe_n=1 and ce_n=1.
- Write buffer: one entry. Loaded on wr_req & wr_ready, which drops wr_ready the next cycle. The buffer clears at the end of WR1, so wr_ready=1 in the cycle after WR1.
- FSM:
  - IDLE -> PRE when buffer valid and (vram_rd=0 or starve_cnt==STARVE_MAX). A vram_rd in that same cycle is still accepted.
  - PRE -> WR0: bus turnaround; the last read completes its SRAM access.
  - WR0 -> WR1: ce_n=0, oe_n=1, we_n=0, addr driven, dq drives {wr_data,wr_data}, only the selected byte enable low.
  - WR1 -> IDLE: we_n=1; addr, dq and byte enables held (data hold time).
- vram_busy = registered (next_state != IDLE). It is high exactly in PRE, WR0 and WR1 (3 cycles per write).
- Starve counter:
  - Increments when state=IDLE, buffer valid and vram_rd=1.
  - Saturates at STARVE_MAX.
  - Clears on entering PRE.
- Read during busy: the read is dropped (no vram_vld) and rd_drop_err pulses one cycle later.
- A write accepted in the same cycle the buffer clears is not possible, because wr_ready is low during WR1.

Decomposition:
- Shared package/header vga_pkg: FSM state encoding (IDLE, PRE, WR0, WR1) and the byte-lane select helper.
- One natural sub-module: vram_wr_buffer (single-entry valid/ready holding register). Everything else stays in the top.

Test Plan:
- Idle reads: vram_rd pulses at addr 0x00000, 0x00001 with SRAM word0=0xBEEF -> vram_vld at T+2 with data 0xEF, then 0xBE. sram_addr=0 and oe_n=0 at T+1.
- Write in read gap: wr_req addr 0x00003 data 0x5A with vram_rd=0 -> busy high 3 cycles. WR0 has we_n=0, ub_n=0, lb_n=1, sram_addr=1, dq=0x5A5A. wr_ready returns 1 after WR1. A later read of 0x00003 returns 0x5A.
- Starvation: vram_rd held high continuously with a write pending -> PRE entered after 16 accepted reads, busy for 3 cycles, all 16+1 reads return vram_vld, no rd_drop_err.
- Protocol violation: vram_rd=1 during WR0 -> no vram_vld for that address, rd_drop_err pulses once.
- Back-to-back reads: 8 consecutive vram_rd cycles -> 8 consecutive vram_vld cycles in order, each exactly 2 cycles after its request.
- Reset mid-write: assert rst_core_n low during WR0 -> we_n=1 and dq=Z immediately, wr_ready=1, busy=0. After release the SRAM word is unchanged if reset preceded the we_n rise, and no retry occurs.
